// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin, burst-locked arbiter that merges NUM_REQ
// operator ap_hs output streams into the single leaf user-to-interface stream.
// A grant is held for up to BURST_LEN words so multi-word messages from one
// operator stay contiguous, and the merged stream leaves through a one-word
// output register.
module leaf_out_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = 8,
    parameter int REQ_BITS     = $clog2(NUM_REQ)
) (
    input  logic                            clk_user,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] in_data,
    input  logic [NUM_REQ-1:0]              in_vld,
    output logic [NUM_REQ-1:0]              in_ack,
    output logic [PAYLOAD_BITS-1:0]         out_data,
    output logic                            out_vld,
    input  logic                            out_ack,
    output logic [REQ_BITS-1:0]             out_src,
    output logic                            grant_vld,
    output logic [REQ_BITS-1:0]             grant_id
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_r;
    logic [REQ_BITS-1:0] ptr_r;
    logic [7:0]          cnt_r;

    logic                    load_ok_s;
    logic                    win_found_s;
    logic [REQ_BITS-1:0]     win_idx_s;
    logic                    acc_s;
    logic [REQ_BITS-1:0]     acc_idx_s;
    logic [PAYLOAD_BITS-1:0] sel_word_s;
    logic [REQ_BITS:0]       cand_s;

    // Round-robin successor of a requester index, wrapping at NUM_REQ.
    function automatic logic [REQ_BITS-1:0] next_idx(input logic [REQ_BITS-1:0] idx);
        if (idx == REQ_BITS'(NUM_REQ - 1)) begin
            next_idx = '0;
        end else begin
            next_idx = idx + REQ_BITS'(1);
        end
    endfunction

    // Output register can take a new word when empty or being drained now.
    assign load_ok_s = !out_vld || out_ack;

    // Find the first valid requester starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, ptr_r} + (REQ_BITS+1)'(k);
            if (cand_s >= (REQ_BITS+1)'(NUM_REQ)) begin
                cand_s = cand_s - (REQ_BITS+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && in_vld[cand_s[REQ_BITS-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[REQ_BITS-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Decide whether a word is accepted this cycle and from which requester.
    always_comb begin
        acc_s     = 1'b0;
        acc_idx_s = '0;
        if (!reset) begin
            acc_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    acc_s     = win_found_s && load_ok_s;
                    acc_idx_s = win_idx_s;
                end
                ST_BURST: begin
                    acc_s     = load_ok_s && in_vld[grant_id];
                    acc_idx_s = grant_id;
                end
                default: begin
                    acc_s     = 1'b0;
                    acc_idx_s = '0;
                end
            endcase
        end
    end

    // One-hot ack and word select for the accepted requester.
    always_comb begin
        in_ack     = '0;
        sel_word_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_ack[i]  = acc_s && (acc_idx_s == REQ_BITS'(i));
            sel_word_s = (acc_idx_s == REQ_BITS'(i)) ?
                         in_data[i*PAYLOAD_BITS +: PAYLOAD_BITS] : sel_word_s;
        end
    end

    // Arbitration FSM: grant, burst counting, release and the output register.
    always_ff @(posedge clk_user) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            cnt_r     <= 8'd0;
            grant_id  <= '0;
            grant_vld <= 1'b0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_s) begin
                        grant_id <= acc_idx_s;
                        cnt_r    <= 8'd1;
                        if (BURST_LEN == 1) begin
                            ptr_r <= next_idx(acc_idx_s);
                        end else begin
                            state_r   <= ST_BURST;
                            grant_vld <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (acc_s) begin
                        cnt_r <= cnt_r + 8'd1;
                        if (cnt_r == 8'(BURST_LEN - 1)) begin
                            state_r   <= ST_IDLE;
                            grant_vld <= 1'b0;
                            ptr_r     <= next_idx(grant_id);
                        end
                    end else if (load_ok_s) begin
                        // Holder bubbled while the output could load: release.
                        state_r   <= ST_IDLE;
                        grant_vld <= 1'b0;
                        ptr_r     <= next_idx(grant_id);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant_vld <= 1'b0;
                end
            endcase

            if (acc_s) begin
                out_data <= sel_word_s;
                out_src  <= acc_idx_s;
                out_vld  <= 1'b1;
            end else if (out_ack) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Self-checking bench for leaf_out_arbiter: a cycle model predicts acks and
// grant state, and a scoreboard queue checks every word leaving the output.
module tb_leaf_out_arbiter;

    localparam int BL_A = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_vld;
    logic [3:0]   in_ack;
    logic [31:0]  out_data;
    logic         out_vld;
    logic         out_ack;
    logic [1:0]   out_src;
    logic         grant_vld;
    logic [1:0]   grant_id;

    logic [3:0]   vld_b;
    logic [3:0]   ack_b;
    logic [31:0]  out_data_b;
    logic         out_vld_b;
    logic         out_ack_b;
    logic [1:0]   out_src_b;
    logic         grant_vld_b;
    logic [1:0]   grant_id_b;

    int n_pass  = 0;
    int n_total = 0;

    // model state
    logic        m_st, m_gvld, m_ovld, m_lok, m_acc, m_found;
    logic [1:0]  m_ptr, m_gid, m_idx;
    int          m_cnt;
    logic [3:0]  exp_ack;
    logic [31:0] base [4];
    int          seq  [4];
    logic [33:0] sb [$];
    logic [33:0] e;

    always #5 clk = ~clk;

    leaf_out_arbiter #(.NUM_REQ(4), .PAYLOAD_BITS(32), .BURST_LEN(BL_A)) dut_a (
        .clk_user(clk), .reset(rst), .in_data(in_data), .in_vld(in_vld),
        .in_ack(in_ack), .out_data(out_data), .out_vld(out_vld), .out_ack(out_ack),
        .out_src(out_src), .grant_vld(grant_vld), .grant_id(grant_id)
    );

    leaf_out_arbiter #(.NUM_REQ(4), .PAYLOAD_BITS(32), .BURST_LEN(1)) dut_b (
        .clk_user(clk), .reset(rst), .in_data(in_data), .in_vld(vld_b),
        .in_ack(ack_b), .out_data(out_data_b), .out_vld(out_vld_b), .out_ack(out_ack_b),
        .out_src(out_src_b), .grant_vld(grant_vld_b), .grant_id(grant_id_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic release_grant();
        m_st   = 1'b0;
        m_gvld = 1'b0;
        m_ptr  = m_gid + 2'd1;
    endtask

    // One clock of stimulus on DUT A: drive, predict, compare, advance model.
    task automatic step(input logic [3:0] v, input logic a, input logic r);
        logic [31:0] w;
        @(negedge clk);
        in_vld  = v;
        out_ack = a;
        rst     = r;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = base[i] + 32'(seq[i]);
        #1;
        m_lok   = !m_ovld || a;
        exp_ack = 4'b0000;
        m_acc   = 1'b0;
        m_idx   = 2'd0;
        m_found = 1'b0;
        if (r) begin
            if (!m_st) begin
                for (int k = 0; k < 4; k++) begin
                    if (!m_found && v[m_ptr + 2'(k)]) begin
                        m_found = 1'b1;
                        m_idx   = m_ptr + 2'(k);
                    end
                end
                m_acc = m_found && m_lok;
            end else begin
                m_idx = m_gid;
                m_acc = m_lok && v[m_gid];
            end
        end
        if (m_acc) exp_ack[m_idx] = 1'b1;
        check("in_ack", 32'(in_ack), 32'(exp_ack));
        check("out_vld", 32'(out_vld), 32'(m_ovld));
        check("grant_vld", 32'(grant_vld), 32'(m_gvld));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        if (m_ovld && a) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", out_data, e[31:0]);
                check("out_src", 32'(out_src), 32'(e[33:32]));
            end
        end
        @(posedge clk);
        if (!r) begin
            m_st = 1'b0; m_ptr = 2'd0; m_cnt = 0; m_gid = 2'd0;
            m_gvld = 1'b0; m_ovld = 1'b0;
            sb.delete();
        end else begin
            if (m_acc) begin
                w = base[m_idx] + 32'(seq[m_idx]);
                sb.push_back({m_idx, w});
                seq[m_idx]++;
                m_ovld = 1'b1;
            end else if (a) begin
                m_ovld = 1'b0;
            end
            if (!m_st) begin
                if (m_acc) begin
                    m_gid = m_idx; m_cnt = 1; m_st = 1'b1; m_gvld = 1'b1;
                end
            end else if (m_acc) begin
                m_cnt++;
                if (m_cnt == BL_A) release_grant();
            end else if (m_lok) begin
                release_grant();
            end
        end
    endtask

    initial begin
        logic [3:0] exp_b [5];
        logic [1:0] src_b [5];
        int gaps;
        base[0] = 32'hA000_0000; base[1] = 32'hB000_0000;
        base[2] = 32'h0000_0100; base[3] = 32'hD000_0000;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        m_st = 1'b0; m_ptr = 2'd0; m_cnt = 0; m_gid = 2'd0; m_gvld = 1'b0; m_ovld = 1'b0;
        rst = 1'b0; in_vld = 4'b0000; out_ack = 1'b0; in_data = '0;
        vld_b = 4'b0000; out_ack_b = 1'b1;

        // reset held with everything requesting
        for (int k = 0; k < 3; k++) step(4'b1111, 1'b1, 1'b0);
        #1;
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);

        // contention: bursts of 4, 0,1,2,3,0...; output never idles
        gaps = 0;
        step(4'b1111, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step(4'b1111, 1'b1, 1'b1);
            #1;
            if (!out_vld) gaps++;
        end
        check("contention_gaps", 32'(gaps), 32'd0);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b1);

        // single requester 2 streaming 0x100..0x10F
        seq[2] = 0;
        for (int k = 0; k < 16; k++) step(4'b0100, 1'b1, 1'b1);
        check("single_count", 32'(seq[2]), 32'd16);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b1);

        // backpressure mid-burst, holder drops vld while stalled
        for (int k = 0; k < 2; k++) step(4'b0001, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) step(4'b0001, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(4'b0001, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b1);

        // bubble release of requester 1 hands over to requester 3
        for (int k = 0; k < 2; k++) step(4'b0010, 1'b1, 1'b1);
        step(4'b1000, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b1010, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b1);

        // reset in the middle of a burst
        for (int k = 0; k < 2; k++) step(4'b0001, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1, 1'b1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // BURST_LEN=1 instance: move ptr to 3, then 0 and 3 alternate
        exp_b[0] = 4'b0100; exp_b[1] = 4'b1000; exp_b[2] = 4'b0001;
        exp_b[3] = 4'b1000; exp_b[4] = 4'b0001;
        src_b[1] = 2'd2; src_b[2] = 2'd3; src_b[3] = 2'd0; src_b[4] = 2'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vld_b = (k == 0) ? 4'b0100 : 4'b1001;
            #1;
            check("b_ack", 32'(ack_b), 32'(exp_b[k]));
            check("b_grant_vld", 32'(grant_vld_b), 32'd0);
            if (k > 0) check("b_out_src", 32'(out_src_b), 32'(src_b[k]));
        end
        @(negedge clk);
        vld_b = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
